// File: rtl/nv_nvdla_reset_pkg.sv
// Shared types and constants for the NVDLA core-domain reset sequencer.
// The counter-width helper is shared so the top and any future users size their counters identically.
package nv_nvdla_reset_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEQ   = 2'd1,
        RUN   = 2'd2,
        PULSE = 2'd3
    } seq_state_e;

    localparam int MIN_SYNC_DEPTH = 2;
    localparam int MIN_PULSE_CYC  = 1;

    // Wide enough for the longest stagger run or the software pulse, whichever is larger.
    function automatic int cnt_width(input int nch, input int stagger, input int pulse);
        int m;
        m = nch * stagger;
        if (pulse > m) begin
            m = pulse;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/nv_nvdla_reset_sync.sv
// Async-assert / sync-deassert reset synchroniser with DFT reset-source mux.
// rst_n_o is the muxed async reset shared by every flop of the sequencer.
module nv_nvdla_reset_sync
    import nv_nvdla_reset_pkg::*;
#(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic direct_reset_i,
    input  logic test_mode_i,
    output logic rst_n_o,
    output logic sync_ok_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  rst_mux_n;

    assign rst_mux_n = test_mode_i ? direct_reset_i : rstn_i;
    assign rst_n_o   = rst_mux_n;

    // Held clear in test mode so leaving DFT always re-runs the full sync delay.
    always_ff @(posedge clk_i or negedge rst_mux_n) begin
        if (!rst_mux_n) begin
            sync_q <= '0;
        end else if (test_mode_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign sync_ok_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/nv_nvdla_reset_seq.sv
// Core-domain reset sequencer: staggered channel release, software per-channel
// reset pulses and a DFT bypass onto direct_reset_.
//
//  state | meaning
//  IDLE  | waiting for the synchronised reset release
//  SEQ   | releasing channels every STAGGER_CYC cycles in index order
//  RUN   | all channels released, accepting software reset requests
//  PULSE | masked channels held low for PULSE_CYC cycles
module nv_nvdla_reset_seq
    import nv_nvdla_reset_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int STAGGER_CYC = 4,
    parameter int PULSE_CYC   = 16
) (
    input  logic           nvdla_clk,
    input  logic           dla_reset_rstn,
    input  logic           direct_reset_,
    input  logic           test_mode,
    input  logic           sw_rst_req,
    input  logic [NCH-1:0] sw_rst_mask,
    output logic           sw_rst_busy,
    output logic [NCH-1:0] synced_rstn,
    output logic           rst_done
);

    localparam int SYNC_D  = (SYNC_DEPTH < MIN_SYNC_DEPTH) ? MIN_SYNC_DEPTH : SYNC_DEPTH;
    localparam int PULSE_C = (PULSE_CYC < MIN_PULSE_CYC) ? MIN_PULSE_CYC : PULSE_CYC;
    localparam int CW      = cnt_width(NCH, STAGGER_CYC, PULSE_C);

    logic           rst_n;
    logic           sync_ok;
    seq_state_e     state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [NCH-1:0] ch_q;
    logic [NCH-1:0] mask_q;
    logic [NCH-1:0] rel_hit;
    logic           busy_q;
    logic           done_q;
    logic           req_ok;

    nv_nvdla_reset_sync #(
        .SYNC_DEPTH (SYNC_D)
    ) u_sync (
        .clk_i          (nvdla_clk),
        .rstn_i         (dla_reset_rstn),
        .direct_reset_i (direct_reset_),
        .test_mode_i    (test_mode),
        .rst_n_o        (rst_n),
        .sync_ok_o      (sync_ok)
    );

    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            rel_hit[i] = (cnt_q == CW'(i * STAGGER_CYC));
        end
    end

    assign cnt_d  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign req_ok = sw_rst_req && (|sw_rst_mask);

    always_ff @(posedge nvdla_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (test_mode) begin
            // Outputs come from direct_reset_ here; park the sequencer so exit starts clean.
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (sync_ok) begin
                        state_q <= SEQ;
                    end
                end
                SEQ: begin
                    ch_q  <= ch_q | rel_hit;
                    cnt_q <= cnt_d;
                    if (rel_hit[NCH-1]) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (req_ok) begin
                        mask_q  <= sw_rst_mask;
                        ch_q    <= ch_q & ~sw_rst_mask;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= PULSE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == CW'(PULSE_C - 1)) begin
                        ch_q    <= ch_q | mask_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign synced_rstn = test_mode ? {NCH{direct_reset_}} : ch_q;
    assign rst_done    = done_q & ~test_mode;
    assign sw_rst_busy = busy_q;

endmodule

// File: tb/tb_nv_nvdla_reset_seq.sv
// Directed bench for nv_nvdla_reset_seq: staggered release, software pulses,
// ignored requests, mid-operation resets, DFT bypass and zero-stagger release.
module tb_nv_nvdla_reset_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       dla_rstn;
    logic       direct_n;
    logic       tmode;
    logic       req;
    logic [2:0] mask;
    logic       busy;
    logic [2:0] syn;
    logic       done;

    logic       rstn4;
    logic       req4;
    logic [3:0] mask4;
    logic       busy4;
    logic [3:0] syn4;
    logic       done4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nv_nvdla_reset_seq #(
        .NCH(3), .SYNC_DEPTH(2), .STAGGER_CYC(4), .PULSE_CYC(16)
    ) u_dut (
        .nvdla_clk      (clk),
        .dla_reset_rstn (dla_rstn),
        .direct_reset_  (direct_n),
        .test_mode      (tmode),
        .sw_rst_req     (req),
        .sw_rst_mask    (mask),
        .sw_rst_busy    (busy),
        .synced_rstn    (syn),
        .rst_done       (done)
    );

    nv_nvdla_reset_seq #(
        .NCH(4), .SYNC_DEPTH(2), .STAGGER_CYC(0), .PULSE_CYC(16)
    ) u_dut4 (
        .nvdla_clk      (clk),
        .dla_reset_rstn (rstn4),
        .direct_reset_  (1'b1),
        .test_mode      (1'b0),
        .sw_rst_req     (req4),
        .sw_rst_mask    (mask4),
        .sw_rst_busy    (busy4),
        .synced_rstn    (syn4),
        .rst_done       (done4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after reset release, before edge 0.
    task automatic power_up_check(input string tag);
        tick(3);
        chk({tag, "_e2_ch"}, 32'(syn), 32'h0);
        tick(1);
        chk({tag, "_e3_ch"}, 32'(syn), 32'h1);
        tick(4);
        chk({tag, "_e7_ch"}, 32'(syn), 32'h3);
        tick(4);
        chk({tag, "_e11_ch"}, 32'(syn), 32'h7);
        chk({tag, "_e11_done"}, 32'(done), 32'h0);
        tick(1);
        chk({tag, "_e12_done"}, 32'(done), 32'h1);
    endtask

    initial begin
        dla_rstn = 1'b0;
        direct_n = 1'b1;
        tmode    = 1'b0;
        req      = 1'b0;
        mask     = 3'b000;
        rstn4    = 1'b0;
        req4     = 1'b0;
        mask4    = 4'h0;

        tick(2);
        chk("rst_ch", 32'(syn), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        dla_rstn = 1'b1;
        power_up_check("pwr");

        // Software pulse on channels 0 and 2, accepted at edge k.
        req  = 1'b1;
        mask = 3'b101;
        tick(1);
        req  = 1'b0;
        chk("pulse_k_ch", 32'(syn), 32'h2);
        chk("pulse_k_busy", 32'(busy), 32'h1);
        chk("pulse_k_done", 32'(done), 32'h0);
        req  = 1'b1;
        mask = 3'b010;
        tick(1);
        req  = 1'b0;
        chk("pulse_ign_ch", 32'(syn), 32'h2);
        chk("pulse_ign_busy", 32'(busy), 32'h1);
        tick(14);
        chk("pulse_k15_ch", 32'(syn), 32'h2);
        chk("pulse_k15_busy", 32'(busy), 32'h1);
        tick(1);
        chk("pulse_k16_ch", 32'(syn), 32'h7);
        chk("pulse_k16_busy", 32'(busy), 32'h0);
        chk("pulse_k16_done", 32'(done), 32'h1);

        req  = 1'b1;
        mask = 3'b000;
        tick(1);
        req  = 1'b0;
        chk("mask0_ch", 32'(syn), 32'h7);
        chk("mask0_busy", 32'(busy), 32'h0);
        chk("mask0_done", 32'(done), 32'h1);

        // Second pulse on channel 1 only, then reset in the middle of it.
        req  = 1'b1;
        mask = 3'b010;
        tick(1);
        req  = 1'b0;
        chk("pulse2_ch", 32'(syn), 32'h5);
        chk("pulse2_busy", 32'(busy), 32'h1);
        tick(5);
        chk("pulse2_k5_ch", 32'(syn), 32'h5);
        #2;
        dla_rstn = 1'b0;
        #1;
        chk("midpulse_rst_ch", 32'(syn), 32'h0);
        chk("midpulse_rst_busy", 32'(busy), 32'h0);
        chk("midpulse_rst_done", 32'(done), 32'h0);
        tick(1);
        dla_rstn = 1'b1;
        power_up_check("repwr1");

        // Restart, ignore a request during SEQ, then reset mid-SEQ.
        tick(1);
        dla_rstn = 1'b0;
        tick(1);
        dla_rstn = 1'b1;
        tick(5);
        req  = 1'b1;
        mask = 3'b111;
        tick(1);
        req  = 1'b0;
        chk("seq_ign_ch", 32'(syn), 32'h1);
        chk("seq_ign_busy", 32'(busy), 32'h0);
        tick(3);
        chk("seq_e8_ch", 32'(syn), 32'h3);
        #2;
        dla_rstn = 1'b0;
        #1;
        chk("midseq_rst_ch", 32'(syn), 32'h0);
        chk("midseq_rst_done", 32'(done), 32'h0);
        tick(1);
        dla_rstn = 1'b1;
        power_up_check("repwr2");

        // DFT bypass.
        tmode = 1'b1;
        #1;
        chk("tm_hi_ch", 32'(syn), 32'h7);
        chk("tm_done", 32'(done), 32'h0);
        direct_n = 1'b0;
        #1;
        chk("tm_lo_ch", 32'(syn), 32'h0);
        direct_n = 1'b1;
        #1;
        chk("tm_hi2_ch", 32'(syn), 32'h7);
        tick(1);
        req  = 1'b1;
        mask = 3'b111;
        tick(1);
        req  = 1'b0;
        chk("tm_req_busy", 32'(busy), 32'h0);
        chk("tm_req_ch", 32'(syn), 32'h7);
        chk("tm_req_done", 32'(done), 32'h0);
        direct_n = 1'b0;
        dla_rstn = 1'b0;
        #1;
        tmode    = 1'b0;
        direct_n = 1'b1;
        tick(1);
        chk("tm_exit_ch", 32'(syn), 32'h0);
        dla_rstn = 1'b1;
        power_up_check("tmexit");

        // Zero stagger, four channels.
        rstn4 = 1'b1;
        tick(3);
        chk("s0_e2_ch", 32'(syn4), 32'h0);
        tick(1);
        chk("s0_e3_ch", 32'(syn4), 32'hF);
        chk("s0_e3_done", 32'(done4), 32'h0);
        tick(1);
        chk("s0_e4_done", 32'(done4), 32'h1);
        chk("s0_e4_busy", 32'(busy4), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
